// File: rtl/wc_pkg.sv
// Shared constants for the Winograd F(5,4) correlation engine: sizes, default taps,
// integer-scaled transform matrices (points 0,+-1,+-2,+-3,inf) and tile types.
package wc_pkg;

  localparam int DW    = 10;
  localparam int N_IN  = 8;
  localparam int N_OUT = 5;
  localparam int N_TAP = 4;

  localparam int G0_DEF = 1;
  localparam int G1_DEF = 2;
  localparam int G2_DEF = -1;
  localparam int G3_DEF = 3;

  // lcm of the Lagrange denominators (-36, 48, -120, 720); divides the output exactly
  localparam int SCALE = 720;

  // Row t: coefficients of prod_{s!=t}(x - p_s); the last row is the full node polynomial
  localparam int BT [N_IN][N_IN] = '{
    '{-36,   0,  49,   0, -14,   0,   1,   0},
    '{  0,  36,  36, -13, -13,   1,   1,   0},
    '{  0, -36,  36,  13, -13,  -1,   1,   0},
    '{  0,  18,   9, -20, -10,   2,   1,   0},
    '{  0, -18,   9,  20, -10,  -2,   1,   0},
    '{  0,  12,   4, -15,  -5,   3,   1,   0},
    '{  0, -12,   4,  15,  -5,  -3,   1,   0},
    '{  0, -36,   0,  49,   0, -14,   0,   1}
  };

  // Row t: SCALE/w_t * [1, p, p^2, p^3]; the inf row picks the leading tap
  localparam int GS [N_IN][N_TAP] = '{
    '{-20,   0,   0,   0},
    '{ 15,  15,  15,  15},
    '{ 15, -15,  15, -15},
    '{ -6, -12, -24, -48},
    '{ -6,  12, -24,  48},
    '{  1,   3,   9,  27},
    '{  1,  -3,   9, -27},
    '{  0,   0,   0, 720}
  };

  localparam int AT [N_OUT][N_IN] = '{
    '{1, 1,  1,  1,  1,  1,   1, 0},
    '{0, 1, -1,  2, -2,  3,  -3, 0},
    '{0, 1,  1,  4,  4,  9,   9, 0},
    '{0, 1, -1,  8, -8, 27, -27, 0},
    '{0, 1,  1, 16, 16, 81,  81, 1}
  };

  function automatic int gg_coef(int t, int g0, int g1, int g2, int g3);
    return GS[t][0] * g0 + GS[t][1] * g1 + GS[t][2] * g2 + GS[t][3] * g3;
  endfunction

  typedef logic [N_IN-1:0][DW-1:0]  tile_in_t;
  typedef logic [N_OUT-1:0][DW-1:0] tile_out_t;

endpackage

// File: rtl/wc_in_xform.sv
// Combinational 8-point Winograd input transform (B^T * d), exact at UW bits.
// Zero latency; no flow control.
module wc_in_xform
  import wc_pkg::*;
#(
  parameter int DW = wc_pkg::DW,
  parameter int UW = DW + 8
) (
  input  logic [N_IN-1:0][DW-1:0] d,
  output logic [N_IN-1:0][UW-1:0] u
);

  logic [UW-1:0] acc;

  // d[N_IN-1] carries d0 (most significant field)
  always_comb begin
    acc = '0;
    u   = '0;
    for (int t = 0; t < N_IN; t++) begin
      acc = '0;
      for (int j = 0; j < N_IN; j++) begin
        acc = acc + UW'(BT[t][j] * int'($signed(d[N_IN-1-j])));
      end
      u[t] = acc;
    end
  end

endmodule

// File: rtl/wc.sv
// Winograd F(5,4) correlation: 8-sample tile in, 5 outputs wrapped to DW bits.
// Latency 3 cycles, one tile per cycle, no handshake or stall.
module wc
  import wc_pkg::*;
#(
  parameter int DW = wc_pkg::DW,
  parameter int G0 = G0_DEF,
  parameter int G1 = G1_DEF,
  parameter int G2 = G2_DEF,
  parameter int G3 = G3_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN*DW-1:0]  D,
  output logic [N_OUT*DW-1:0] Z
);

  localparam int UW = DW + 8;
  localparam int MW = UW + 16;
  localparam int AW = MW + 8;

  logic [N_IN-1:0][DW-1:0]  din;
  logic [N_IN-1:0][UW-1:0]  u;
  logic [N_IN-1:0][UW-1:0]  u_q;
  logic [N_IN-1:0][MW-1:0]  m;
  logic [N_IN-1:0][MW-1:0]  m_q;
  logic [N_OUT-1:0][DW-1:0] y;
  logic [N_OUT-1:0][DW-1:0] z_q;
  logic signed [AW-1:0]     acc;

  assign din = D;

  wc_in_xform #(
    .DW (DW),
    .UW (UW)
  ) u_xf (
    .d (din),
    .u (u)
  );

  // Pre-transformed filter taps are elaboration-time constants
  for (genvar t = 0; t < N_IN; t++) begin : g_mul
    localparam int GGT = gg_coef(t, G0, G1, G2, G3);
    assign m[t] = MW'($signed(u_q[t])) * MW'(GGT);
  end

  // The scaled sum is an exact multiple of SCALE, so division rounding never matters
  always_comb begin
    acc = '0;
    y   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      acc = '0;
      for (int t = 0; t < N_IN; t++) begin
        acc = acc + AW'(AT[i][t]) * AW'($signed(m_q[t]));
      end
      y[N_OUT-1-i] = DW'(acc / AW'(SCALE));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_q <= '0;
      m_q <= '0;
      z_q <= '0;
    end else begin
      u_q <= u;
      m_q <= m;
      z_q <= y;
    end
  end

  assign Z = z_q;

endmodule

// File: tb/tb_wc.sv
// Self-checking bench for wc: directed tiles plus random streams against a direct-form model.
module tb_wc;
  import wc_pkg::*;

  localparam int TG [4] = '{1, 2, -1, 3};

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  tile_in_t  D   = '0;
  tile_out_t Z;

  int errors = 0;
  int checks = 0;

  wc #(
    .DW (10),
    .G0 (TG[0]),
    .G1 (TG[1]),
    .G2 (TG[2]),
    .G3 (TG[3])
  ) dut (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .Z   (Z)
  );

  always #5 clk = ~clk;

  function automatic tile_in_t pk_in(int a0, int a1, int a2, int a3,
                                     int a4, int a5, int a6, int a7);
    tile_in_t r;
    r[7] = 10'(a0); r[6] = 10'(a1); r[5] = 10'(a2); r[4] = 10'(a3);
    r[3] = 10'(a4); r[2] = 10'(a5); r[1] = 10'(a6); r[0] = 10'(a7);
    return r;
  endfunction

  function automatic tile_out_t pk_out(int y0, int y1, int y2, int y3, int y4);
    tile_out_t r;
    r[4] = 10'(y0); r[3] = 10'(y1); r[2] = 10'(y2); r[1] = 10'(y3); r[0] = 10'(y4);
    return r;
  endfunction

  function automatic tile_in_t rnd_tile();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  // Direct-form correlation, kept modulo 2^10
  function automatic tile_out_t ref_y(tile_in_t t);
    tile_out_t r;
    int s;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += int'($signed(t[7-i-k])) * TG[k];
      r[4-i] = 10'(s);
    end
    return r;
  endfunction

  task automatic drive_and_wait(input tile_in_t t);
    D = t;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      D = rnd_tile();
      @(posedge clk); #1;
      checks++;
      if (Z !== '0) begin
        errors++;
        $display("FAIL reset_hold: Z=%h required 0", Z);
      end
    end
    D   = '0;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (Z !== '0) begin
        errors++;
        $display("FAIL post_reset_zero cycle %0d: Z=%h required 0", c, Z);
      end
    end
  endtask

  task automatic test_tiles();
    tile_out_t e1, e2;
    e1 = pk_out(-9, -47, -30, -52, -117);
    e2 = pk_out(-61, -27, 30, -56, 14);
    D = pk_in(2, -10, 3, 4, -13, -18, -16, -28);
    @(posedge clk); #1;
    D = pk_in(-19, -6, 3, -9, -12, 11, -4, 0);
    @(posedge clk); #1;
    D = '0;
    checks++;
    if (Z !== '0) begin
      errors++;
      $display("FAIL latency_early: Z=%h required 0", Z);
    end
    @(posedge clk); #1;
    checks++;
    if (Z !== e1) begin
      errors++;
      $display("FAIL tile1: Z=%h required %h", Z, e1);
    end
    @(posedge clk); #1;
    checks++;
    if (Z !== e2) begin
      errors++;
      $display("FAIL tile2_back_to_back: Z=%h required %h", Z, e2);
    end
  endtask

  task automatic test_impulse();
    tile_out_t e;
    drive_and_wait(pk_in(0, 0, 0, 1, 0, 0, 0, 0));
    e = pk_out(3, -1, 2, 1, 0);
    checks++;
    if (Z !== e) begin
      errors++;
      $display("FAIL impulse_d3: Z=%h required %h", Z, e);
    end
    drive_and_wait(pk_in(1, 0, 0, 0, 0, 0, 0, 0));
    e = pk_out(1, 0, 0, 0, 0);
    checks++;
    if (Z !== e) begin
      errors++;
      $display("FAIL impulse_d0: Z=%h required %h", Z, e);
    end
  endtask

  task automatic test_wrap();
    tile_out_t e;
    drive_and_wait(pk_in(511, 511, 511, 511, 511, 511, 511, 511));
    e = pk_out(507, 507, 507, 507, 507);
    checks++;
    if (Z !== e) begin
      errors++;
      $display("FAIL wrap_max: Z=%h required %h", Z, e);
    end
    @(posedge clk); #1;
    checks++;
    if (Z !== e) begin
      errors++;
      $display("FAIL hold_stable: Z=%h required %h", Z, e);
    end
    drive_and_wait(pk_in(-512, -512, -512, -512, -512, -512, -512, -512));
    e = pk_out(-512, -512, -512, -512, -512);
    checks++;
    if (Z !== e) begin
      errors++;
      $display("FAIL wrap_min: Z=%h required %h", Z, e);
    end
  endtask

  task automatic test_random_stream();
    tile_in_t tiles [40];
    tile_out_t e;
    for (int c = 0; c < 43; c++) begin
      @(posedge clk); #1;
      if (c >= 3) begin
        e = ref_y(tiles[c-3]);
        checks++;
        if (Z !== e) begin
          errors++;
          $display("FAIL random_tile %0d: Z=%h required %h", c - 3, Z, e);
        end
      end
      if (c < 40) begin
        tiles[c] = rnd_tile();
        D = tiles[c];
      end
    end
  endtask

  task automatic test_mid_reset();
    localparam int L  = 30;
    localparam int RC = 12;
    tile_in_t tiles [L];
    bit       dead  [L];
    tile_out_t e;
    for (int c = 0; c < L + 3; c++) begin
      @(posedge clk); #1;
      if (c >= 3) begin
        e = dead[c-3] ? '0 : ref_y(tiles[c-3]);
        checks++;
        if (Z !== e) begin
          errors++;
          $display("FAIL mid_reset_tile %0d: Z=%h required %h", c - 3, Z, e);
        end
      end
      if (c < L) begin
        tiles[c] = rnd_tile();
        dead[c]  = 1'b0;
        D = tiles[c];
      end
      if (c == RC) begin
        dead[RC-1] = 1'b1;
        dead[RC-2] = 1'b1;
        rst = 1'b0;
        #2;
        checks++;
        if (Z !== '0) begin
          errors++;
          $display("FAIL async_clear: Z=%h required 0", Z);
        end
        #2;
        rst = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tiles();
    test_impulse();
    test_wrap();
    test_random_stream();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wc.md
Name: wc

Overview:
- Fixed-filter 1-D Winograd F(5,4) correlation engine.
- Each cycle it takes one tile of 8 signed 10-bit samples and produces 5 signed 10-bit outputs, y[i] = sum over k=0..3 of d[i+k]*g[k].
- The 4-tap filter g is a compile-time constant.
- Sits in the convolution datapath as a fully pipelined, stall-free tile processor.

Parameters:
- DW, 10, width of each input sample and each output element (two's complement).
- G0, 1, filter tap g[0] (signed integer).
- G1, 2, filter tap g[1].
- G2, -1, filter tap g[2].
- G3, 3, filter tap g[3].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- D  input  8*DW  input tile. d0=D[79:70], d1=D[69:60], … d7=D[9:0] (d0 in the most significant field).
- Z  output  5*DW  output tile. y0=Z[49:40], y1=Z[39:30], … y4=Z[9:0] (y0 in the most significant field).

Behaviour:
- Function: y[i] = d[i]*G0 + d[i+1]*G1 + d[i+2]*G2 + d[i+3]*G3, for i=0..4.
- Arithmetic: all internal arithmetic is exact, at full width (at least DW+8 bits signed).
- Output width: each y[i] is truncated to its low DW bits, i.e. wraps modulo 2^DW. There is no saturation.
- Bit-exactness is the requirement; the architecture only has to meet it.
- Reference architecture, three register stages:
  - Stage 1: input transform B^T·d, producing 8 terms.
  - Stage 2: 8 element-wise products with the pre-transformed filter (G·g). All transform constants are scaled to integers by a common denominator.
  - Stage 3: output transform A^T·m, then exact division by that denominator, then truncation to DW.
- Latency: D sampled at rising edge N appears on Z after rising edge N+3. This is a fixed 3-cycle latency.
- Throughput: one new tile per cycle. There is no handshake, no valid signal and no stall.
- Reset, rst low: immediately clears all pipeline registers and Z to 0, asynchronously.
- After rst deasserts: Z keeps showing 0 until the first tile sampled after reset has crossed all 3 stages.
- Reset mid-stream: in-flight tiles are discarded, not completed.
- Constant input: if D is held, Z is stable from cycle N+3 onward.
- Boundary: extreme inputs (-512, +511) must not overflow internal registers. Only the final truncation wraps.

Decomposition:
- Shared package wc_pkg holds:
  - DW, N_IN=8, N_OUT=5, N_TAP=4;
  - default filter taps;
  - integer-scaled Winograd B^T/G/A^T constant arrays and the scale denominator;
  - packed tile typedefs (8×DW in, 5×DW out).
- One natural sub-module: wc_in_xform, the combinational 8-point input transform, instantiated once in stage 1.
- The multiplies and the output transform stay in wc.

Test Plan:
- Reset: hold rst low with D random -> Z=0. Release rst, apply D=0 -> Z remains 0 for all cycles.
- Tile 1: D = d [2,-10,3,4,-13,-18,-16,-28] -> 3 cycles later y = [-9,-47,-30,-52,-117].
- Tile 2, back-to-back with tile 1: D = d [-19,-6,3,-9,-12,11,-4,0].
  - On the next cycle, y = [-61,-27,30,-56,14].
  - Confirms a new result every cycle and the 3-cycle latency.
- Impulse response: d3=1, others 0 -> y = [3,-1,2,1,0]. d0=1, others 0 -> y = [1,0,0,0,0]. Checks tap ordering and field packing.
- Wrap: all d=+511 -> exact 2555 per output -> Z elements = 507. All d=-512 -> exact -2560 -> Z elements = -512 (10'b1000000000).
- Mid-stream reset: stream random tiles, pulse rst low for half a cycle.
  - Z drops to 0 asynchronously during the pulse.
  - The first nonzero Z after release corresponds to the first tile sampled after release, 3 cycles later.
  - Random tiles are compared against a direct-form model modulo 1024.
